// File: rtl/fetch_prefetch_unit.sv
// rtl/fetch_prefetch_unit.sv - instruction fetch stage: PC generator, credit-limited imem requests, prefetch FIFO, redirect flush
// Optional FETCH_PERF_CNT_EN adds the perf_starve_cycles counter port.
module fetch_prefetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]     perf_starve_cycles,
`endif
    output logic [XLEN-1:0] out_pc
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    typedef logic [CW-1:0] cnt_t;

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_resp_pc;
    cnt_t            r_count;
    cnt_t            r_inflight;
    cnt_t            r_drop_cnt;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [31:0]     r_mem_inst [FIFO_DEPTH];
    logic [XLEN-1:0] r_mem_pc   [FIFO_DEPTH];

    logic [CW:0]     w_used;
    logic            w_req_fire;
    logic            w_drop_active;
    logic            w_push;
    logic            w_pop;
    logic [XLEN-1:0] w_redirect_pc;
    cnt_t            w_inflight_after_rsp;

    // Credit covers FIFO entries plus outstanding requests, so a response always has room.
    assign w_used         = {1'b0, r_count} + {1'b0, r_inflight};
    assign imem_req_valid = !reset && !redirect_valid && (w_used < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_drop_active  = (r_drop_cnt != '0);
    assign w_push         = imem_rsp_valid && !w_drop_active && !redirect_valid;
    assign out_valid      = (r_count != '0) && !redirect_valid;
    assign w_pop          = out_valid && out_ready;
    assign out_inst       = out_valid ? r_mem_inst[r_rd_ptr] : '0;
    assign out_pc         = out_valid ? r_mem_pc[r_rd_ptr]   : '0;

    assign w_redirect_pc        = redirect_pc & ~XLEN'(3);
    assign w_inflight_after_rsp = r_inflight - cnt_t'(imem_rsp_valid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_count    <= '0;
            r_inflight <= '0;
            r_drop_cnt <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else if (redirect_valid) begin
            // Every request still outstanding after this edge belongs to the old path.
            r_fetch_pc <= w_redirect_pc;
            r_resp_pc  <= w_redirect_pc;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_inflight <= w_inflight_after_rsp;
            r_drop_cnt <= w_inflight_after_rsp;
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
            end
            r_inflight <= w_inflight_after_rsp + cnt_t'(w_req_fire);
            if (imem_rsp_valid) begin
                if (w_drop_active) begin
                    r_drop_cnt <= r_drop_cnt - cnt_t'(1);
                end else begin
                    r_resp_pc <= r_resp_pc + XLEN'(4);
                end
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + cnt_t'(w_push) - cnt_t'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_inst[r_wr_ptr] <= imem_rsp_data;
            r_mem_pc[r_wr_ptr]   <= r_resp_pc;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_starve;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_starve <= '0;
        end else if (out_ready && !out_valid && !redirect_valid && (r_perf_starve != '1)) begin
            r_perf_starve <= r_perf_starve + 32'd1;
        end
    end

    assign perf_starve_cycles = r_perf_starve;
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb/tb_fetch_prefetch_unit.sv - randomized scoreboard bench for fetch_prefetch_unit
module tb_fetch_prefetch_unit;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_starve_cycles;
`endif

    fetch_prefetch_unit #(.XLEN(32), .RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
`ifdef FETCH_PERF_CNT_EN
        .perf_starve_cycles(perf_starve_cycles),
`endif
        .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; int epoch; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;

    pend_t pend[$];
    exp_t  exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    int rdy_pct = 0, ordy_pct = 0, redir_pct = 0, lat_min = 1, lat_max = 1;
    logic        force_redir = 1'b0;
    logic [31:0] force_pc = '0;

    int          cyc = 0;
    int          epoch = 0;
    int          acc_cnt = 0;
    int          pop_cnt = 0;
    logic [31:0] exp_fetch = RST_PC;
    logic [31:0] exp_perf = '0;
    logic        want_first = 1'b0;
    logic [31:0] first_pc = '0;
    logic [31:0] prev_pc = '0;
    logic        saw_wrap = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Stimulus, memory model and reference fetch model.
    initial begin
        logic  redir, fire, ov_exp, prev_redir;
        pend_t p;
        prev_redir = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                pend.delete();
                exp_q.delete();
                exp_fetch      = RST_PC;
                exp_perf       = '0;
                epoch++;
                want_first     = 1'b1;
                first_pc       = 32'hDEAD_BEEF;
                imem_req_ready = 1'b0;
                imem_rsp_valid = 1'b0;
                redirect_valid = 1'b0;
                out_ready      = 1'b0;
                prev_redir     = 1'b0;
                continue;
            end
            imem_rsp_valid = 1'b0;
            if (pend.size() != 0 && pend[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend[0].addr);
            end
            redir = 1'b0;
            if (force_redir) begin
                redir = 1'b1;
                redirect_pc = force_pc;
                force_redir = 1'b0;
            end else if (!prev_redir && $urandom_range(99) < redir_pct) begin
                redir = 1'b1;
                redirect_pc = ($urandom_range(3) == 0) ? $urandom : ($urandom & 32'h0000_0FFF);
            end
            prev_redir     = redir;
            redirect_valid = redir;
            imem_req_ready = ($urandom_range(99) < rdy_pct);
            out_ready      = ($urandom_range(99) < ordy_pct);
            #1;
            ov_exp = (exp_q.size() != 0) && !redir;
            chk("req_valid", {31'b0, imem_req_valid},
                {31'b0, !redir && (exp_q.size() + pend.size() < DEPTH)});
            chk("out_valid", {31'b0, out_valid}, {31'b0, ov_exp});
            if (!out_valid) chk("idle_out_zero", out_pc | out_inst, 32'h0);
`ifdef FETCH_PERF_CNT_EN
            chk("perf_cnt", perf_starve_cycles, exp_perf);
            if (out_ready && !ov_exp && !redir) exp_perf++;
`endif
            fire = imem_req_valid && imem_req_ready;
            if (fire) begin
                chk("req_addr", imem_req_addr, exp_fetch);
                p.addr  = exp_fetch;
                p.due   = cyc + $urandom_range(lat_max, lat_min);
                p.epoch = epoch;
                pend.push_back(p);
                exp_fetch += 32'd4;
                acc_cnt++;
            end
            if (imem_rsp_valid) begin
                p = pend.pop_front();
                if (p.epoch == epoch && !redir)
                    exp_q.push_back('{pc: p.addr, inst: mem_word(p.addr)});
            end
            if (redir) begin
                epoch++;
                exp_q.delete();
                exp_fetch  = redirect_pc & ~32'h3;
                want_first = 1'b1;
                first_pc   = 32'hDEAD_BEEF;
            end
        end
    end

    // Monitor: pops the scoreboard whenever decode accepts an instruction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && out_valid && out_ready) begin
                pop_cnt++;
                if (want_first) begin
                    first_pc   = out_pc;
                    want_first = 1'b0;
                end
                if (prev_pc == 32'hFFFF_FFFC && out_pc == 32'h0) saw_wrap = 1'b1;
                prev_pc = out_pc;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_output: got pc %h, none expected", out_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_pc", out_pc, e.pc);
                    chk("out_inst", out_inst, e.inst);
                end
            end
        end
    end

    task automatic knobs(input int rp, input int orp, input int rdp, input int lmin, input int lmax);
        rdy_pct = rp; ordy_pct = orp; redir_pct = rdp; lat_min = lmin; lat_max = lmax;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        @(posedge clk);
        force_pc    = pc;
        force_redir = 1'b1;
    endtask

    initial begin
        int p0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #4;
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        chk("rst_req_addr", imem_req_addr, RST_PC);
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        @(negedge clk);
        #3 reset = 1'b0;

        // Streaming with a single-cycle memory.
        @(posedge clk); knobs(100, 100, 0, 1, 1);
        repeat (30) @(posedge clk);
        chk("first_pc_after_reset", first_pc, RST_PC);
        p0 = pop_cnt;
        repeat (10) @(posedge clk);
        chk("throughput_10cyc", pop_cnt - p0, 10);

        // Backpressure: credits run out, one pop frees exactly one request.
        knobs(100, 0, 0, 1, 1);
        repeat (12) @(posedge clk);
        @(negedge clk); #1;
        chk("stall_req_valid", {31'b0, imem_req_valid}, 32'h0);
        @(posedge clk); ordy_pct = 100;
        @(posedge clk); ordy_pct = 0; acc_cnt = 0;
        repeat (6) @(posedge clk);
        chk("one_pop_one_req", acc_cnt, 1);

        // Redirects with a slow memory, a misaligned target, and PC wrap.
        knobs(100, 100, 0, 3, 3);
        repeat (10) @(posedge clk);
        do_redirect(32'h0000_0100);
        repeat (15) @(posedge clk);
        chk("redirect_first_pc", first_pc, 32'h0000_0100);
        do_redirect(32'h0000_0203);
        repeat (15) @(posedge clk);
        chk("misaligned_first_pc", first_pc, 32'h0000_0200);
        knobs(100, 100, 0, 1, 1);
        saw_wrap = 1'b0;
        do_redirect(32'hFFFF_FFF4);
        repeat (15) @(posedge clk);
        chk("pc_wrap_seen", {31'b0, saw_wrap}, 32'h1);

        // Randomized traffic.
        knobs(70, 70, 3, 1, 4);
        repeat (1500) @(posedge clk);

        // Asynchronous reset with a full FIFO.
        knobs(100, 0, 0, 1, 1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        #3 reset = 1'b1;
        #1;
        chk("async_rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("async_rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        chk("async_rst_req_addr", imem_req_addr, RST_PC);
`ifdef FETCH_PERF_CNT_EN
        chk("async_rst_perf", perf_starve_cycles, 32'h0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        #3 reset = 1'b0;
        @(posedge clk); knobs(100, 100, 0, 1, 2);
        repeat (30) @(posedge clk);
        chk("restart_first_pc", first_pc, RST_PC);
        knobs(0, 100, 0, 1, 1);
        repeat (10) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
